mc_conunit: RTL

Multi-cycle control unit for the MIPS-subset CPU. It sequences a shared datapath (one ALU, register file, PC/IR registers, single memory port) through IF/ID/EXE/MEM/WB states, one instruction at a time. It waits on a memory-ready handshake and counts retired instructions. It supports the same instruction set and datapath select encodings as the single-cycle control unit.

---
 rtl/mc_conunit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mc_conunit.sv
// rtl/mc_conunit.sv - multi-cycle MIPS-subset control unit (IF/ID/EXE/MEM/WB sequencer)
module mc_conunit #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  input  logic             Z,
  input  logic             Mrdy,
  output logic             Rmem,
  output logic             Wmem,
  output logic             Wir,
  output logic             Wpc,
  output logic [1:0]       Pcsrc,
  output logic             Wreg,
  output logic             Regrt,
  output logic             Se,
  output logic             Aluqb,
  output logic [1:0]       Aluc,
  output logic             Reg2reg,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] Icnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] icnt;
  logic             retire;

  logic r_type, i_add, i_sub, i_and, i_or;
  logic i_addi, i_andi, i_ori, i_lw, i_sw, i_beq, i_bne, i_j;
  logic legal, branch, taken;

  assign r_type = (Op == 6'b000000);
  assign i_add  = r_type && (Func == 6'b100000);
  assign i_sub  = r_type && (Func == 6'b100010);
  assign i_and  = r_type && (Func == 6'b100100);
  assign i_or   = r_type && (Func == 6'b100101);
  assign i_addi = (Op == 6'b001000);
  assign i_andi = (Op == 6'b001100);
  assign i_ori  = (Op == 6'b001101);
  assign i_lw   = (Op == 6'b100011);
  assign i_sw   = (Op == 6'b101011);
  assign i_beq  = (Op == 6'b000100);
  assign i_bne  = (Op == 6'b000101);
  assign i_j    = (Op == 6'b000010);

  assign branch = i_beq | i_bne;
  assign taken  = (i_beq & Z) | (i_bne & ~Z);
  assign legal  = i_add | i_sub | i_and | i_or | i_addi | i_andi | i_ori |
                  i_lw | i_sw | branch | i_j;

  // Datapath selects follow the instruction in every state, like the single-cycle unit.
  assign Regrt   = i_addi | i_andi | i_ori | i_lw | i_sw | branch | i_j;
  assign Se      = i_addi | i_lw | i_sw | branch;
  assign Aluqb   = i_add | i_sub | i_and | i_or | branch | i_j;
  assign Aluc    = (i_sub | branch)  ? 2'b01 :
                   (i_and | i_andi)  ? 2'b10 :
                   (i_or  | i_ori)   ? 2'b11 : 2'b00;
  assign Reg2reg = ~i_lw;

  assign State = state;
  assign Icnt  = icnt;

  always_comb begin
    retire = 1'b0;
    case (state)
      S_ID:    retire = i_j | ~legal;
      S_EXE:   retire = branch;
      S_MEM:   retire = i_sw & Mrdy;
      S_WB:    retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_comb begin
    Rmem  = 1'b0;
    Wmem  = 1'b0;
    Wir   = 1'b0;
    Wpc   = 1'b0;
    Pcsrc = 2'b00;
    Wreg  = 1'b0;
    if (!Rst) begin
      case (state)
        S_IF: begin
          Rmem = 1'b1;
          Wir  = Mrdy;
          Wpc  = Mrdy;
        end
        S_ID: begin
          if (i_j) begin
            Wpc   = 1'b1;
            Pcsrc = 2'b11;
          end
        end
        S_EXE: begin
          if (taken) begin
            Wpc   = 1'b1;
            Pcsrc = 2'b10;
          end
        end
        S_MEM: begin
          Wmem = i_sw;
          Rmem = i_lw;
        end
        S_WB:    Wreg = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= S_IF;
      icnt  <= '0;
    end else begin
      if (retire) icnt <= icnt + {{(CNT_W-1){1'b0}}, 1'b1};
      case (state)
        S_IF:  if (Mrdy) state <= S_ID;
        S_ID:  state <= (i_j || !legal) ? S_IF : S_EXE;
        S_EXE: begin
          if (branch)             state <= S_IF;
          else if (i_lw || i_sw)  state <= S_MEM;
          else                    state <= S_WB;
        end
        S_MEM: if (Mrdy) state <= i_sw ? S_IF : S_WB;
        S_WB:  state <= S_IF;
        default: state <= S_IF;
      endcase
    end
  end

endmodule
